input_scan_conditioner: RTL and testbench

- Sits directly upstream of the processor's IN bus, between the raw PLC field inputs and the core's input register.
- Synchronises each raw input and debounces it with a per-channel counter.
- Records sticky rising/falling-edge events per channel.
- On each four-phase scan handshake, freezes a coherent input image plus edge flags, so one program scan sees stable, glitch-free inputs.

---
 rtl/input_scan_conditioner.sv | 136 +++++++++++++
 tb/tb_input_scan_conditioner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_scan_conditioner.sv
// Field-input conditioner: two-flop synchroniser, per-channel debounce, sticky edge flags,
// and a four-phase scan handshake that freezes a coherent input image for one program scan.
module input_scan_conditioner #(
    parameter int IN_NUM     = 8,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_NUM-1:0] raw_in,
    input  logic              scan_req,
    output logic              scan_ack,
    output logic [IN_NUM-1:0] in_image,
    output logic [IN_NUM-1:0] rise_img,
    output logic [IN_NUM-1:0] fall_img,
    output logic [IN_NUM-1:0] deb_live,
    output logic              chg_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    logic [IN_NUM-1:0] r_sync_p0;
    logic [IN_NUM-1:0] r_sync_p1;
    logic [IN_NUM-1:0] r_deb;
    logic [CNT_W-1:0]  r_cnt [IN_NUM];
    logic              r_chg;

    logic [IN_NUM-1:0] r_rise;
    logic [IN_NUM-1:0] r_fall;
    logic [IN_NUM-1:0] r_img;
    logic [IN_NUM-1:0] r_rimg;
    logic [IN_NUM-1:0] r_fimg;
    logic              r_ack;
    state_t            r_state;

    logic [IN_NUM-1:0] w_acc;
    logic [CNT_W-1:0]  w_cnt_nxt [IN_NUM];
    logic [IN_NUM-1:0] w_deb_nxt;
    logic [IN_NUM-1:0] w_rise_ev;
    logic [IN_NUM-1:0] w_fall_ev;

    // Any agreement with the accepted level restarts the count, so only unbroken runs accept.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync_p1[i] != r_deb[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_acc[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_deb_nxt = r_deb ^ w_acc;
    assign w_rise_ev = w_acc & r_sync_p1;
    assign w_fall_ev = w_acc & ~r_sync_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_deb     <= '0;
            r_chg     <= 1'b0;
            for (int i = 0; i < IN_NUM; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync_p0 <= raw_in;
            r_sync_p1 <= r_sync_p0;
            r_deb     <= w_deb_nxt;
            r_chg     <= |w_acc;
            for (int i = 0; i < IN_NUM; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Capture uses next-state values so an acceptance on the capture edge lands in this
    // snapshot; the sticky flags are cleared rather than also holding that event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_img   <= '0;
            r_rimg  <= '0;
            r_fimg  <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (scan_req) begin
                        r_img   <= w_deb_nxt;
                        r_rimg  <= r_rise | w_rise_ev;
                        r_fimg  <= r_fall | w_fall_ev;
                        r_rise  <= '0;
                        r_fall  <= '0;
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end else begin
                        r_rise <= r_rise | w_rise_ev;
                        r_fall <= r_fall | w_fall_ev;
                    end
                end
                ACK: begin
                    r_rise <= r_rise | w_rise_ev;
                    r_fall <= r_fall | w_fall_ev;
                    if (!scan_req) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign scan_ack  = r_ack;
    assign in_image  = r_img;
    assign rise_img  = r_rimg;
    assign fall_img  = r_fimg;
    assign deb_live  = r_deb;
    assign chg_pulse = r_chg;

endmodule

// File: tb/tb_input_scan_conditioner.sv
// Bench for input_scan_conditioner: directed scenarios plus randomized traffic, checked
// against a window-based reference model of debounce and snapshot behaviour.
module tb_input_scan_conditioner;

    localparam int N   = 8;
    localparam int DEB = 4;
    localparam int CW  = 3;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic [N-1:0] raw_in   = '0;
    logic         scan_req = 1'b0;
    logic         scan_ack;
    logic [N-1:0] in_image, rise_img, fall_img, deb_live;
    logic         chg_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    input_scan_conditioner #(.IN_NUM(N), .DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .scan_req(scan_req),
        .scan_ack(scan_ack), .in_image(in_image), .rise_img(rise_img),
        .fall_img(fall_img), .deb_live(deb_live), .chg_pulse(chg_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted when the DEB most recent synchronised samples
    // (raw delayed two edges) all differ from the accepted level.
    logic [N-1:0] m_deb = '0, m_rise = '0, m_fall = '0;
    logic [N-1:0] m_img = '0, m_rimg = '0, m_fimg = '0;
    logic         m_ack = 1'b0, m_chg = 1'b0;
    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_acc, m_new, m_rev, m_fev;
    logic         m_alldiff, m_smp;
    int           m_idx;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_deb = '0; m_rise = '0; m_fall = '0;
            m_img = '0; m_rimg = '0; m_fimg = '0;
            m_ack = 1'b0; m_chg = 1'b0;
            m_hist.delete();
        end else begin
            m_hist.push_back(raw_in);
            if (m_hist.size() > DEB + 2) void'(m_hist.pop_front());
            m_acc = '0;
            for (int ch = 0; ch < N; ch++) begin
                m_alldiff = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    m_idx = m_hist.size() - 3 - j;
                    m_smp = (m_idx >= 0) ? m_hist[m_idx][ch] : 1'b0;
                    if (m_smp == m_deb[ch]) m_alldiff = 1'b0;
                end
                m_acc[ch] = m_alldiff;
            end
            m_new = m_deb ^ m_acc;
            m_rev = m_acc & m_new;
            m_fev = m_acc & ~m_new;
            m_chg = |m_acc;
            if (!m_ack && scan_req) begin
                m_img  = m_new;
                m_rimg = m_rise | m_rev;
                m_fimg = m_fall | m_fev;
                m_rise = '0;
                m_fall = '0;
                m_ack  = 1'b1;
            end else begin
                m_rise = m_rise | m_rev;
                m_fall = m_fall | m_fev;
                if (m_ack && !scan_req) m_ack = 1'b0;
            end
            m_deb = m_new;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++;
        if ({scan_ack, in_image, rise_img, fall_img, deb_live, chg_pulse} !== '0)
            $display("FAIL reset_outputs got=%h want=0",
                     {scan_ack, in_image, rise_img, fall_img, deb_live, chg_pulse});
        else n_pass++;
        reset = 1'b1;
        tick(2);
        n_checks++;
        if ({scan_ack, in_image, deb_live, chg_pulse} !== '0)
            $display("FAIL reset_release_idle got=%h want=0", {scan_ack, in_image, deb_live, chg_pulse});
        else n_pass++;
    endtask

    task automatic test_debounce_rise();
        int edges = 0;
        raw_in = 8'h01;
        for (int k = 1; k <= 20 && edges == 0; k++) begin
            @(negedge clk);
            if (deb_live[0]) edges = k;
        end
        n_checks++;
        if (edges != DEB + 2) $display("FAIL deb_latency got=%0d want=%0d", edges, DEB + 2);
        else n_pass++;
        n_checks++;
        if (chg_pulse !== 1'b1) $display("FAIL chg_pulse_high got=%b want=1", chg_pulse);
        else n_pass++;
        tick(1);
        n_checks++;
        if (chg_pulse !== 1'b0 || deb_live !== 8'h01)
            $display("FAIL chg_pulse_one_cycle got=%b/%h want=0/01", chg_pulse, deb_live);
        else n_pass++;
    endtask

    task automatic test_glitch();
        tick(2);
        raw_in[3] = 1'b1;
        tick(3);
        raw_in[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (deb_live[3] !== 1'b0 || chg_pulse !== 1'b0 || deb_live !== m_deb)
                $display("FAIL glitch_reject cyc=%0d got=%h/%b want=%h/0", k, deb_live, chg_pulse, m_deb);
            else n_pass++;
        end
        scan_req = 1'b1;
        tick(1);
        n_checks++;
        if (rise_img[3] !== 1'b0 || fall_img[3] !== 1'b0)
            $display("FAIL glitch_sticky got=%b%b want=00", rise_img[3], fall_img[3]);
        else n_pass++;
        scan_req = 1'b0;
        tick(1);
    endtask

    task automatic test_snapshot();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        raw_in = 8'hA5;
        tick(DEB + 4);
        scan_req = 1'b1;
        tick(1);
        n_checks++;
        if ({scan_ack, in_image, rise_img, fall_img} !== {1'b1, 8'hA5, 8'hA5, 8'h00})
            $display("FAIL snapshot_capture got=%b %h %h %h want=1 a5 a5 00",
                     scan_ack, in_image, rise_img, fall_img);
        else n_pass++;
        raw_in = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if ({scan_ack, in_image, rise_img, fall_img} !== {1'b1, 8'hA5, 8'hA5, 8'h00})
                $display("FAIL snapshot_hold cyc=%0d got=%b %h %h %h want=1 a5 a5 00",
                         k, scan_ack, in_image, rise_img, fall_img);
            else n_pass++;
        end
        scan_req = 1'b0;
        tick(1);
        n_checks++;
        if (scan_ack !== 1'b0 || in_image !== 8'hA5 || deb_live !== 8'h5A)
            $display("FAIL snapshot_release got=%b %h %h want=0 a5 5a", scan_ack, in_image, deb_live);
        else n_pass++;
    endtask

    task automatic test_double_edge();
        raw_in[2] = 1'b1;
        tick(DEB + 4);
        scan_req = 1'b1; tick(1); scan_req = 1'b0; tick(1);
        raw_in[2] = 1'b0;
        tick(DEB + 4);
        raw_in[2] = 1'b1;
        tick(DEB + 4);
        scan_req = 1'b1;
        tick(1);
        n_checks++;
        if ({rise_img[2], fall_img[2], in_image[2]} !== 3'b111 || rise_img !== m_rimg || fall_img !== m_fimg)
            $display("FAIL double_edge got=%b%b%b rise=%h fall=%h want=111 rise=%h fall=%h",
                     rise_img[2], fall_img[2], in_image[2], rise_img, fall_img, m_rimg, m_fimg);
        else n_pass++;
        scan_req = 1'b0; tick(2);
        scan_req = 1'b1; tick(1);
        n_checks++;
        if (rise_img !== 8'h00 || fall_img !== 8'h00)
            $display("FAIL quiet_snapshot got=%h/%h want=00/00", rise_img, fall_img);
        else n_pass++;
        scan_req = 1'b0; tick(1);
    endtask

    task automatic test_same_edge();
        raw_in[5] = 1'b0;
        tick(DEB + 4);
        scan_req = 1'b1; tick(1); scan_req = 1'b0; tick(1);
        raw_in[5] = 1'b1;
        tick(DEB + 1);
        scan_req = 1'b1;
        tick(1);
        n_checks++;
        if ({in_image[5], rise_img[5], deb_live[5]} !== 3'b111)
            $display("FAIL same_edge_capture got=%b%b%b want=111", in_image[5], rise_img[5], deb_live[5]);
        else n_pass++;
        scan_req = 1'b0; tick(2);
        scan_req = 1'b1; tick(1);
        n_checks++;
        if (rise_img[5] !== 1'b0 || in_image[5] !== 1'b1)
            $display("FAIL same_edge_not_retained got=%b%b want=01", rise_img[5], in_image[5]);
        else n_pass++;
        scan_req = 1'b0; tick(1);
    endtask

    task automatic test_reset_mid_ack();
        int edges = 0;
        raw_in = 8'hFF;
        tick(DEB + 4);
        scan_req = 1'b1;
        tick(1);
        n_checks++;
        if (in_image !== 8'hFF || scan_ack !== 1'b1)
            $display("FAIL ack_precondition got=%h/%b want=ff/1", in_image, scan_ack);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({scan_ack, in_image, rise_img, fall_img, deb_live, chg_pulse} !== '0)
            $display("FAIL async_reset got=%h want=0",
                     {scan_ack, in_image, rise_img, fall_img, deb_live, chg_pulse});
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 20 && edges == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (scan_ack !== 1'b1 || in_image !== 8'h00)
                    $display("FAIL recapture_after_reset got=%b/%h want=1/00", scan_ack, in_image);
                else n_pass++;
            end
            if (deb_live === 8'hFF) edges = k;
        end
        n_checks++;
        if (edges != DEB + 2) $display("FAIL reset_deb_latency got=%0d want=%0d", edges, DEB + 2);
        else n_pass++;
        scan_req = 1'b0;
        tick(1);
    endtask

    task automatic test_random();
        int hold[N];
        for (int ch = 0; ch < N; ch++) hold[ch] = $urandom_range(1, 8);
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            n_checks++;
            if ({scan_ack, in_image, rise_img, fall_img, deb_live, chg_pulse} !==
                {m_ack, m_img, m_rimg, m_fimg, m_deb, m_chg})
                $display("FAIL random cyc=%0d got ack=%b img=%h r=%h f=%h live=%h chg=%b want ack=%b img=%h r=%h f=%h live=%h chg=%b",
                         cyc, scan_ack, in_image, rise_img, fall_img, deb_live, chg_pulse,
                         m_ack, m_img, m_rimg, m_fimg, m_deb, m_chg);
            else n_pass++;
            for (int ch = 0; ch < N; ch++) begin
                hold[ch]--;
                if (hold[ch] <= 0) begin
                    raw_in[ch] = ~raw_in[ch];
                    hold[ch] = $urandom_range(1, 8);
                end
            end
            if ($urandom_range(0, 5) == 0) scan_req = ~scan_req;
        end
        scan_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce_rise();
        test_glitch();
        test_snapshot();
        test_double_edge();
        test_same_edge();
        test_reset_mid_ack();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1);
    end

endmodule
